uart_rx: RTL

Serial UART receiver that deserialises an asynchronous `Rx` line into parallel words. It sits directly upstream of the receive FIFO and drives that FIFO's `Rx_Data` / `Data_Rdy` inputs. It performs start-bit qualification, mid-bit sampling, optional parity checking and stop-bit checking. Only error-free frames produce a `Data_Rdy` pulse.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// UART receiver port bundle: serial line in, parallel word and
// status pulses out toward the receive FIFO.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 Rx;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Data_Rdy;
  logic                 Parity_Err;
  logic                 Frame_Err;
  logic                 Rx_Busy;

  modport slave (
    input  Rx,
    output Rx_Data,
    output Data_Rdy,
    output Parity_Err,
    output Frame_Err,
    output Rx_Busy
  );

  modport master (
    output Rx,
    input  Rx_Data,
    input  Data_Rdy,
    input  Parity_Err,
    input  Frame_Err,
    input  Rx_Busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start qualification, mid-bit sampling, optional
// parity and stop checks; only clean frames raise Data_Rdy.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD  = (PARITY_ODD != 0);
  localparam logic          PEN  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bits_q;
  logic [DATA_BITS-1:0] sr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 pflag_q;
  logic                 rdy_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      pflag_q <= 1'b0;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.Rx};
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            bits_q  <= '0;
            pflag_q <= 1'b0;
            state_q <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q  <= '0;
            sr_q   <= {rx_s, sr_q[DATA_BITS-1:1]};
            bits_q <= bits_q + 1'b1;
            if (bits_q == LAST)
              state_q <= PEN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            pflag_q <= (^sr_q) ^ rx_s ^ ODD;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            if (rx_s) begin
              if (pflag_q) begin
                perr_q <= 1'b1;
              end else begin
                data_q <= sr_q;
                rdy_q  <= 1'b1;
              end
              state_q <= S_IDLE;
            end else begin
              // a low stop bit may be a break; hold until the line recovers
              ferr_q  <= 1'b1;
              perr_q  <= pflag_q;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Rx_Data    = data_q;
  assign bus.Data_Rdy   = rdy_q;
  assign bus.Parity_Err = perr_q;
  assign bus.Frame_Err  = ferr_q;
  assign bus.Rx_Busy    = (state_q != S_IDLE);
endmodule
